noc_output_arbiter: RTL
=======================

# noc_output_arbiter

Per-output-port switch arbiter and link driver for the mesh router. Five input blocks (N, E, S, W, local) each present a flit stream already routed to this output port. The arbiter grants one whole packet at a time using round-robin, with wormhole lock from head flit to tail flit. Flits leave on the link through a register, and per-VC credit counters gate transmission against the downstream input FIFO.

## Interface
Parameters:
- CHANNELS, Noc_VC_Channel: number of virtual channels on the output link; VCW = max(1, $clog2(CHANNELS)).
- DEPTH, Noc_VC_Fifo_Depth: downstream per-VC FIFO depth, which is the initial credit count; CW = $clog2(DEPTH+1).
- FLIT_WIDTH, Noc_Flit_Width: flit payload width.
- ACTIVATE_PORT, 5'b11111: input enable mask. A cleared bit means that input is never granted and its in_ready is 0.

Ports:
- noc_clk  in  1  sole clock.
- noc_rst  in  1  synchronous, active-high reset.
- in_valid  in  5  per-input flit valid.
- in_head  in  5  flit is a packet head.
- in_tail  in  5  flit is a packet tail. head and tail may both be set (single-flit packet).
- in_vc  in  5*VCW  requested output VC, valid with in_valid.
- in_flit  in  5*FLIT_WIDTH  flit payload.
- in_ready  out  5  flit accepted this cycle when in_valid&in_ready.
- grant  out  5  one-hot owner of the output, 0 when idle.
- out_valid  out  1  link flit valid.
- out_flit  out  FLIT_WIDTH  link payload.
- out_vc  out  VCW  link VC.
- out_head, out_tail  out  1 each  framing copied from the input.
- credit_in  in  CHANNELS  one-cycle pulse per freed downstream slot, per VC.
- err_credit  out  1  sticky; set on credit overflow.

## Operation
- States:
  - IDLE: no owner.
  - LOCKED: owner index o in 0..4 and locked VC v are registered.
- In IDLE, candidate i requires all of:
  - ACTIVATE_PORT[i]
  - in_valid[i]
  - in_head[i]
  - credit[in_vc[i]] > 0
- Round-robin pick: start at rr_ptr, pick the first candidate in increasing index, wrapping at 4→0.
  - On a pick: o is set to the winner, v is set to its in_vc, and the state goes to LOCKED.
  - No flit is accepted in the IDLE cycle.
- IDLE ignores non-head flits. They are never accepted and never granted.
- in_ready[i] = (state==LOCKED) && (i==o) && (credit[v] > 0), combinational from registers only.
- Transfer occurs when in_valid[o] && in_ready[o]. On a transfer:
  - out_valid, out_flit, out_vc=v, out_head and out_tail are registered.
  - credit[v] decrements.
  - The in_vc of body and tail flits is ignored; v stays locked.
- A transfer with in_tail set moves the state to IDLE and sets rr_ptr = (o+1) mod 5.
- Zero credits during LOCKED: in_ready drops, the lock holds, and the packet resumes when a credit returns. No other input is granted meanwhile.
- Input bubbles (in_valid low while LOCKED) hold the lock. out_valid is 0 in any cycle after a non-transfer.
- Credit counter per VC, width CW:
  - +1 on credit_in[c].
  - −1 on a transfer on c.
  - Both in the same cycle: unchanged.
  - Increment at DEPTH with no decrement: saturate at DEPTH and set err_credit.
  - The counter never underflows, because a transfer is gated by credit>0.
- grant is the one-hot of o while LOCKED, else 0.

## Timing
- Reset (synchronous, takes effect at the edge where noc_rst=1):
  - state IDLE, rr_ptr 0, grant 0, in_ready 0.
  - out_valid 0, out_flit 0, out_vc 0, out_head 0, out_tail 0.
  - all credits = DEPTH, err_credit 0.
- Reset mid-packet drops the lock. Partial packets are the system's concern; the arbiter resumes in IDLE with full credits.
- Arbitration: a head is visible in cycle t, giving LOCKED at t+1 with in_ready high in t+1 when credit allows. The head is on the link (out_valid) at t+2.
- Streaming: 1 flit/cycle while credit>0. Link latency is 1 cycle from input transfer to out_valid.
- An N-flit packet occupies N+1 cycles minimum (one arbitration cycle).
- A credit_in in cycle t is usable (in_ready high) in cycle t+1.
- Back-to-back packets from different inputs:
  - The tail transfers at t, IDLE at t+1 with arbitration, LOCKED at t+2.

## Test plan
- Reset, then a 3-flit packet on input 2, VC 1, CHANNELS=2, DEPTH=4:
  - grant=00100 one cycle after the head is presented.
  - Three consecutive out_valid cycles with out_vc=1, head on the first, tail on the third.
  - credit[1]=1 afterwards, and grant=0 after the tail.
- Inputs 0, 1 and 4 all hold single-flit heads continuously from reset:
  - grant order is 0,1,4,0,1,4.
  - Each packet takes 2 cycles (arbitration cycle + 1 flit).
- 6-flit packet with DEPTH=4 and no credit_in:
  - 4 flits pass, then in_ready=0 with grant held.
  - Pulse credit_in[v] twice on separate cycles: exactly 2 more flits pass, tail included, and the state returns to IDLE.
- Same-cycle credit_in[v] and transfer on v: credit unchanged. credit_in at credit=DEPTH: credit stays DEPTH and err_credit=1, remaining 1 until reset.
- ACTIVATE_PORT=5'b11110 with a head on input 0 only: no grant and in_ready[0]=0 indefinitely. A non-head flit on input 3 in IDLE is never accepted.
- Assert noc_rst during flit 2 of a 4-flit packet:
  - next cycle grant=0, out_valid=0, credits=DEPTH.
  - A fresh head on input 1 is then granted normally.

Source files
------------

// File: rtl/noc_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : noc_output_arbiter
// Description : Per-output-port round-robin wormhole arbiter and registered
//               link driver with per-VC downstream credit counters.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_output_arbiter #(
    parameter int         CHANNELS      = 2,
    parameter int         DEPTH         = 4,
    parameter int         FLIT_WIDTH    = 32,
    parameter logic [4:0] ACTIVATE_PORT = 5'b11111,
    localparam int        VCW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int        CW            = $clog2(DEPTH + 1)
) (
    input  logic                    noc_clk,
    input  logic                    noc_rst,
    input  logic [4:0]              in_valid,
    input  logic [4:0]              in_head,
    input  logic [4:0]              in_tail,
    input  logic [5*VCW-1:0]        in_vc,
    input  logic [5*FLIT_WIDTH-1:0] in_flit,
    output logic [4:0]              in_ready,
    output logic [4:0]              grant,
    output logic                    out_valid,
    output logic [FLIT_WIDTH-1:0]   out_flit,
    output logic [VCW-1:0]          out_vc,
    output logic                    out_head,
    output logic                    out_tail,
    input  logic [CHANNELS-1:0]     credit_in,
    output logic                    err_credit
);

    localparam logic [0:0]    c_IDLE   = 1'b0;
    localparam logic [0:0]    c_LOCKED = 1'b1;
    localparam logic [CW-1:0] c_DEPTH  = CW'(DEPTH);

    logic [0:0]          r_state;
    logic [2:0]          r_owner;
    logic [2:0]          r_rr_ptr;
    logic [VCW-1:0]      r_vc;
    logic [CW-1:0]       r_credit [CHANNELS];
    logic                r_err;
    logic                r_out_valid;
    logic [FLIT_WIDTH-1:0] r_out_flit;
    logic [VCW-1:0]      r_out_vc;
    logic                r_out_head;
    logic                r_out_tail;

    logic [4:0]          w_cand;
    logic [4:0]          w_grant;
    logic                w_pick_valid;
    logic [2:0]          w_pick_idx;
    logic [VCW-1:0]      w_pick_vc;
    logic                w_own_credit;
    logic                w_xfer;
    logic                w_sel_tail;
    logic                w_sel_head;
    logic [FLIT_WIDTH-1:0] w_sel_flit;
    logic [CHANNELS-1:0] w_dec;

    function automatic logic [2:0] f_wrap(input logic [2:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= 5) s = s - 5;
        return 3'(s);
    endfunction

    // A head is only a candidate if its requested VC currently has credit
    always_comb begin
        w_cand = '0;
        for (int i = 0; i < 5; i++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (in_vc[i*VCW +: VCW] == VCW'(c) && r_credit[c] != '0)
                    w_cand[i] = ACTIVATE_PORT[i] & in_valid[i] & in_head[i];
            end
        end
    end

    // Descending scan so the lowest rotated offset from rr_ptr wins
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        w_pick_vc    = '0;
        for (int k = 4; k >= 0; k--) begin
            if (w_cand[f_wrap(r_rr_ptr, k)]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = f_wrap(r_rr_ptr, k);
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (w_pick_idx == 3'(i)) w_pick_vc = in_vc[i*VCW +: VCW];
        end
    end

    always_comb begin
        w_own_credit = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (r_vc == VCW'(c) && r_credit[c] != '0) w_own_credit = 1'b1;
        end
    end

    for (genvar i = 0; i < 5; i++) begin : g_port
        assign w_grant[i]  = (r_state == c_LOCKED) && (r_owner == 3'(i));
        assign in_ready[i] = w_grant[i] & w_own_credit;
    end

    assign w_xfer     = |(in_valid & in_ready);
    assign w_sel_head = |(in_head & w_grant);
    assign w_sel_tail = |(in_tail & w_grant);

    always_comb begin
        w_sel_flit = '0;
        for (int i = 0; i < 5; i++) begin
            if (w_grant[i]) w_sel_flit = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
        end
    end

    always_comb begin
        w_dec = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_dec[c] = w_xfer && (r_vc == VCW'(c));
        end
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            r_state  <= c_IDLE;
            r_owner  <= '0;
            r_vc     <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_pick_valid) begin
                        r_state <= c_LOCKED;
                        r_owner <= w_pick_idx;
                        r_vc    <= w_pick_vc;
                    end
                end
                c_LOCKED: begin
                    if (w_xfer && w_sel_tail) begin
                        r_state  <= c_IDLE;
                        r_rr_ptr <= (r_owner == 3'd4) ? 3'd0 : r_owner + 3'd1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
            r_out_vc    <= '0;
            r_out_head  <= 1'b0;
            r_out_tail  <= 1'b0;
        end else begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
                r_out_flit <= w_sel_flit;
                r_out_vc   <= r_vc;
                r_out_head <= w_sel_head;
                r_out_tail <= w_sel_tail;
            end
        end
    end

    // Simultaneous return and consume on one VC cancel out
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            r_err <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) r_credit[c] <= c_DEPTH;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (credit_in[c] && !w_dec[c]) begin
                    if (r_credit[c] == c_DEPTH) r_err <= 1'b1;
                    else r_credit[c] <= r_credit[c] + CW'(1);
                end else if (!credit_in[c] && w_dec[c]) begin
                    r_credit[c] <= r_credit[c] - CW'(1);
                end
            end
        end
    end

    assign grant      = w_grant;
    assign out_valid  = r_out_valid;
    assign out_flit   = r_out_flit;
    assign out_vc     = r_out_vc;
    assign out_head   = r_out_head;
    assign out_tail   = r_out_tail;
    assign err_credit = r_err;

endmodule
`default_nettype wire
